// File: rtl/n_bit_counter.sv
// Prescaled up/down counter with modulo range, wrap or saturate at the
// limit, synchronous clamped load and a one-cycle terminal-count pulse.
//
// Parameters:
//   WIDTH      : counter width in bits (1..32)
//   MODULO     : count range is 0..MODULO-1 (2..2^WIDTH)
//   PRESC_BITS : prescaler width (1..32); one count step per 2^PRESC_BITS
//                enabled cycles
module n_bit_counter #(
    parameter int unsigned     WIDTH      = 4,
    parameter longint unsigned MODULO     = 16,
    parameter int unsigned     PRESC_BITS = 22
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_in,
    input  logic             up_in,
    input  logic             mode_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] load_data_in,
    output logic [WIDTH-1:0] data,
    output logic             tc_out
);

    // Largest legal count value and small typed constants.
    localparam logic [WIDTH-1:0]      MAX_VAL = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0]      ZERO    = '0;
    localparam logic [WIDTH-1:0]      ONE     = WIDTH'(1);
    localparam logic [PRESC_BITS-1:0] P_MAX   = '1;
    localparam logic [PRESC_BITS-1:0] P_ONE   = PRESC_BITS'(1);

    // When MODULO fills the whole WIDTH range no load value can be out of
    // range, so the clamp comparator is omitted.
    localparam bit FULL_RANGE = (MODULO == (64'd1 << WIDTH));

    logic [PRESC_BITS-1:0] presc_q, presc_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic                  tc_q, tc_d;
    logic                  tick;
    logic                  at_term;
    logic [WIDTH-1:0]      load_val;

    // Clamp the load value into 0..MODULO-1.
    generate
        if (FULL_RANGE) begin : g_no_clamp
            assign load_val = load_data_in;
        end else begin : g_clamp
            assign load_val = (load_data_in > MAX_VAL) ? MAX_VAL : load_data_in;
        end
    endgenerate

    // Tick fires on the enabled edge at which the prescaler is all-ones.
    assign tick = en_in && (presc_q == P_MAX);

    // Terminal value depends on the direction sampled at the tick edge.
    assign at_term = up_in ? (data_q == MAX_VAL) : (data_q == ZERO);

    // Next-state logic: load beats tick, tick beats hold.
    always_comb begin
        presc_d = presc_q;
        data_d  = data_q;
        tc_d    = 1'b0;
        if (load_in) begin
            presc_d = '0;
            data_d  = load_val;
        end else begin
            if (en_in) begin
                presc_d = presc_q + P_ONE;
            end
            if (tick) begin
                if (!at_term) begin
                    data_d = up_in ? (data_q + ONE) : (data_q - ONE);
                end else begin
                    // Terminal pulse on every tick at the limit, wrap or hold.
                    tc_d = 1'b1;
                    if (!mode_in) begin
                        data_d = up_in ? ZERO : MAX_VAL;
                    end
                end
            end
        end
    end

    // State registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            presc_q <= '0;
            data_q  <= '0;
            tc_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            data_q  <= data_d;
            tc_q    <= tc_d;
        end
    end

    assign data   = data_q;
    assign tc_out = tc_q;

endmodule

// File: doc/n_bit_counter.md
N_BIT_COUNTER -- requirements
Module: n_bit_counter

Interface
- REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 1..32.
- REQ-002 Parameter MODULO, default 16: count range 0..MODULO-1, legal range 2..2^WIDTH.
- REQ-003 Parameter PRESC_BITS, default 22: prescaler width, legal range 1..32; the count advances once every 2^PRESC_BITS enabled cycles.
- REQ-004 Port clk_in, input, 1 bit: single clock; all state changes on its rising edge.
- REQ-005 Port rst_in, input, 1 bit: reset, asynchronous, active-high.
- REQ-006 Port en_in, input, 1 bit: count enable; the prescaler and the counter advance only while en_in=1.
- REQ-007 Port up_in, input, 1 bit: direction; 1 counts up, 0 counts down.
- REQ-008 Port mode_in, input, 1 bit: limit mode; 0 wraps at the limit, 1 saturates at the limit.
- REQ-009 Port load_in, input, 1 bit: synchronous load strobe.
- REQ-010 Port load_data_in, input, WIDTH bits: value to load.
- REQ-011 Port data, output, WIDTH bits: current count, registered.
- REQ-012 Port tc_out, output, 1 bit: terminal-count pulse, registered.

Function
- REQ-013 The prescaler shall be a PRESC_BITS-bit counter that increments by 1 on each edge with en_in=1 and holds when en_in=0.
- REQ-014 The prescaler shall wrap from all-ones to 0.
- REQ-015 tick shall be internal and combinational: tick = en_in AND (prescaler == 2^PRESC_BITS-1).
- REQ-016 Priority at each edge shall be, highest first: load_in, then tick, then hold.
- REQ-017 When load_in=1, data shall take min(load_data_in, MODULO-1) and the prescaler shall clear to 0.
  - This applies regardless of en_in and tick.
  - tc_out shall be 0 on the following cycle.
- REQ-018 The terminal value shall be MODULO-1 when up_in=1 and 0 when up_in=0; up_in and mode_in shall be sampled only on a tick edge.
- REQ-019 On a tick with data not at the terminal value, data shall step by +1 (up) or -1 (down).
- REQ-020 On a tick with data at the terminal value and mode_in=0, data shall wrap:
  - up: MODULO-1 -> 0;
  - down: 0 -> MODULO-1.
- REQ-021 On a tick with data at the terminal value and mode_in=1, data shall hold its value.
- REQ-022 tc_out shall be 1 for exactly one cycle, on the cycle after each tick edge at which data was at the terminal value, and 0 at all other times.
- REQ-023 In saturate mode, tc_out shall pulse on every tick while data remains at the limit.
- REQ-024 Any direction change shall take effect at the next tick with no extra latency.
- REQ-025 The first data step after enable shall occur on the 2^PRESC_BITS-th enabled edge.
- REQ-026 Arithmetic shall be modulo MODULO; data shall never exceed MODULO-1 under any input sequence.

Reset
- REQ-027 While rst_in=1, and immediately without waiting for a clock edge, data=0, prescaler=0 and tc_out=0.
- REQ-028 On rst_in deassertion, operation shall resume with the first step on the 2^PRESC_BITS-th enabled edge.
- REQ-029 Reset asserted mid-count, or during load, shall override all other inputs.

Verification
All scenarios use WIDTH=4, MODULO=10, PRESC_BITS=1, so one tick occurs every 2 enabled cycles.
- REQ-030 Reset, then en=1, up=1, mode=0 -> data steps 0,1,...,9,0 every 2 cycles; tc_out is a single 1-cycle pulse as data goes 9->0.
- REQ-031 From data=0 with up=0 -> data goes 0->9->8, with a tc_out pulse on the 0->9 wrap.
- REQ-032 load_in=1 with load_data_in=12 -> data=9 next cycle. Then load_in=1 with load_data_in=5 on a tick edge -> data=5 (load beats tick) and the prescaler restarts from 0.
- REQ-033 mode=1, up=1 from data=7 -> 8, 9, then data holds 9 while tc_out pulses on every tick. Switch up=0 -> data goes 9->8 at the next tick.
- REQ-034 en=0 for 10 cycles at data=4 -> data stays 4, tc_out stays 0; re-enable -> 5 after 2 enabled cycles.
- REQ-035 rst_in pulsed mid-cycle at data=6 -> data=0 and tc_out=0 before the next clock edge; counting resumes 0->1 after release.
